// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_write_arbiter_pkg;

    // Architectural register file geometry
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    // Default hardwired-zero register index (never written, never tracked)
    localparam int unsigned RF_ZERO_REG = 31;

    // Requester index encoding
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_e;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    // True when a destination index refers to a real (writable) register
    function automatic logic is_writable(input reg_addr_t addr, input reg_addr_t zero_addr);
        return addr != zero_addr;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-way round-robin arbiter. Grants are combinational; the last granted
// requester is remembered so that the other one wins the next tie.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    req_idx_e last_q;
    req_idx_e last_d;

    // Grant selection: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        gnt_o = '0;
        if (rst_ni) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (last_q == REQ_MEM) ? 2'b01 : 2'b10;
                default: gnt_o = '0;
            endcase
        end
    end

    // Every grant is a transfer (grant implies valid), so history follows the grant
    always_comb begin
        last_d = last_q;
        if (gnt_o[0]) begin
            last_d = REQ_ALU;
        end else if (gnt_o[1]) begin
            last_d = REQ_MEM;
        end
    end

    // Last-grant history; resets to MEM so the ALU wins the first tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= REQ_MEM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file writeback arbiter: merges ALU and memory writebacks onto a
// single registered write port and keeps a pending-write scoreboard used for
// source-operand hazard detection.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ZERO_REG = regfile_write_arbiter_pkg::RF_ZERO_REG
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,

    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,

    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,

    input  logic [ADDR_W-1:0]   SA,
    input  logic [ADDR_W-1:0]   SB,
    output logic                hazard_a,
    output logic                hazard_b,

    output logic                W,
    output logic [ADDR_W-1:0]   DA,
    output logic [DATA_W-1:0]   D,

    output logic [NUM_REGS-1:0] busy,
    output logic                rsv_err
);

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

    logic [1:0]          gnt;
    logic                xfer;
    reg_addr_t           xfer_addr;
    logic [DATA_W-1:0]   xfer_data;
    logic                xfer_we;
    logic                rsv_en;

    logic                W_q,  W_d;
    reg_addr_t           DA_q, DA_d;
    logic [DATA_W-1:0]   D_q,  D_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                rsv_err_q, rsv_err_d;

    rr_arbiter2 u_arb (
        .clk_i  (clock),
        .rst_ni (reset),
        .req_i  ({req1_valid, req0_valid}),
        .gnt_o  (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Winning request; a zero-register transfer is accepted but produces no write
    always_comb begin
        xfer      = |gnt;
        xfer_addr = gnt[1] ? req1_addr : req0_addr;
        xfer_data = gnt[1] ? req1_data : req0_data;
        xfer_we   = xfer & is_writable(xfer_addr, ZERO_ADDR);
        rsv_en    = rsv_valid & is_writable(rsv_addr, ZERO_ADDR);
    end

    // Write-port next state: W pulses per write, DA/D hold when idle
    always_comb begin
        W_d  = xfer_we;
        DA_d = DA_q;
        D_d  = D_q;
        if (xfer_we) begin
            DA_d = xfer_addr;
            D_d  = xfer_data;
        end
    end

    // Scoreboard next state: clear on write first, then reserve so a same-cycle reserve wins
    always_comb begin
        busy_d = busy_q;
        if (xfer_we) begin
            busy_d[xfer_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        rsv_err_d = rsv_en & busy_q[rsv_addr];
    end

    // Write-port, scoreboard and error-pulse registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            W_q       <= 1'b0;
            DA_q      <= '0;
            D_q       <= '0;
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            W_q       <= W_d;
            DA_q      <= DA_d;
            D_q       <= D_d;
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    // Hazards look only at registered state; same-cycle writebacks are not bypassed
    always_comb begin
        hazard_a = busy_q[SA] & is_writable(SA, ZERO_ADDR);
        hazard_b = busy_q[SB] & is_writable(SB, ZERO_ADDR);
    end

    assign W       = W_q;
    assign DA      = DA_q;
    assign D       = D_q;
    assign busy    = busy_q;
    assign rsv_err = rsv_err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  SA, SB;
    logic        hazard_a, hazard_b;
    logic        W;
    logic [4:0]  DA;
    logic [63:0] D;
    logic [31:0] busy;
    logic        rsv_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    regfile_write_arbiter #(.DATA_W(64), .ZERO_REG(31)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .SA         (SA),
        .SB         (SB),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .W          (W),
        .DA         (DA),
        .D          (D),
        .busy       (busy),
        .rsv_err    (rsv_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {grant1, grant0} from the arbitration rules
    function automatic logic [1:0] exp_grant(input logic rst, input logic v0, input logic v1,
                                             input logic last);
        if (!rst)          return 2'b00;
        if (v0 && !v1)     return 2'b01;
        if (v1 && !v0)     return 2'b10;
        if (v0 && v1)      return last ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    // Behavioural model state
    logic        m_last;
    logic        m_W;
    logic [4:0]  m_DA;
    logic [63:0] m_D;
    logic [31:0] m_busy;
    logic        m_err;

    // Compare process: check on every falling edge, advance the model on every rising edge
    initial begin
        logic [1:0]  g;
        logic [4:0]  a;
        logic [63:0] d;
        logic        e;
        m_last = 1'b1; m_W = 1'b0; m_DA = '0; m_D = '0; m_busy = '0; m_err = 1'b0;
        forever begin
            @(negedge clock);
            g = exp_grant(reset, req0_valid, req1_valid, m_last);
            chk("ready0",   req0_ready, g[0]);
            chk("ready1",   req1_ready, g[1]);
            chk("hazard_a", hazard_a, (SA != 5'd31) && m_busy[SA]);
            chk("hazard_b", hazard_b, (SB != 5'd31) && m_busy[SB]);
            chk("W",        W,        m_W);
            chk("DA",       DA,       m_DA);
            chk("D",        D,        m_D);
            chk("busy",     busy,     m_busy);
            chk("rsv_err",  rsv_err,  m_err);
            @(posedge clock);
            if (!reset) begin
                m_last = 1'b1; m_W = 1'b0; m_DA = '0; m_D = '0; m_busy = '0; m_err = 1'b0;
            end else begin
                g = exp_grant(1'b1, req0_valid, req1_valid, m_last);
                e = rsv_valid && (rsv_addr != 5'd31) && m_busy[rsv_addr];
                m_W = 1'b0;
                if (g != 2'b00) begin
                    m_last = g[1];
                    a = g[1] ? req1_addr : req0_addr;
                    d = g[1] ? req1_data : req0_data;
                    if (a != 5'd31) begin
                        m_W = 1'b1;
                        m_DA = a;
                        m_D = d;
                        m_busy[a] = 1'b0;
                    end
                end
                if (rsv_valid && rsv_addr != 5'd31) m_busy[rsv_addr] = 1'b1;
                m_err = e;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'h1;
        req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; SA = '0; SB = '0;
        #2;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_W", W, 1'b0);
        chk("rst_busy", busy, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        req0_valid = 1'b0;

        // Reserve R5, then ALU writes R5
        rsv_valid = 1'b1; rsv_addr = 5'd5; SA = 5'd5;
        cyc();
        rsv_valid = 1'b0;
        #1 chk("s1_hazard_set", hazard_a, 1'b1);
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hDEAD;
        #1 chk("s1_hazard_xfer", hazard_a, 1'b1);
        chk("s1_ready0", req0_ready, 1'b1);
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("s1_W", W, 1'b1);
        chk("s1_DA", DA, 5'd5);
        chk("s1_D", D, 64'hDEAD);
        chk("s1_busy5", busy[5], 1'b0);
        chk("s1_hazard_clr", hazard_a, 1'b0);

        // MEM writes the zero register
        req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 64'hFFFF; SA = 5'd31;
        #1;
        chk("s3_ready1", req1_ready, 1'b1);
        chk("s3_hazard_a", hazard_a, 1'b0);
        cyc();
        req1_valid = 1'b0;
        #1;
        chk("s3_W", W, 1'b0);
        chk("s3_busy", busy, 32'h0);

        // Both requesters valid for four cycles
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s2_ready0", req0_ready, (i % 2) == 0);
            chk("s2_ready1", req1_ready, (i % 2) == 1);
            cyc();
            #1;
            chk("s2_W", W, 1'b1);
            chk("s2_DA", DA, ((i % 2) == 0) ? 5'd1 : 5'd2);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reserve and write R7 in the same cycle, then reserve R7 again
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'h77;
        cyc();
        req0_valid = 1'b0; rsv_valid = 1'b0;
        #1;
        chk("s4_busy7", busy[7], 1'b1);
        chk("s4_err0", rsv_err, 1'b0);
        chk("s4_W", W, 1'b1);
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        cyc();
        rsv_valid = 1'b0;
        #1 chk("s4_err1", rsv_err, 1'b1);
        cyc();
        #1 chk("s4_err_end", rsv_err, 1'b0);

        // Reset pulse during a transfer cycle
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h33;
        cyc();
        #1 chk("s5_W_pre", W, 1'b1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("s5_W_rst", W, 1'b0);
        chk("s5_busy_rst", busy, 32'h0);
        chk("s5_ready0_rst", req0_ready, 1'b0);
        @(posedge clock);
        #3 reset = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 64'h44;
        #1;
        chk("s5_tie_ready0", req0_ready, 1'b1);
        chk("s5_tie_ready1", req1_ready, 1'b0);
        chk("s5_W_after", W, 1'b0);
        chk("s5_busy_after", busy, 32'h0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_addr  = rnd_addr();
            req1_addr  = rnd_addr();
            req0_data  = {$urandom, $urandom};
            req1_data  = {$urandom, $urandom};
            rsv_valid  = ($urandom_range(0, 2) == 0);
            rsv_addr   = rnd_addr();
            SA         = rnd_addr();
            SB         = rnd_addr();
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsv_valid = 1'b0;
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning width of writeback data and of the D bus.
REQ-002 SHALL have parameter ZERO_REG, default 31, meaning the hardwired-zero register index, which is never written.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each, writeback request from requester 0 (ALU) and requester 1 (memory).
REQ-006 SHALL have ports req0_addr / req1_addr, input, 5 each, destination register.
REQ-007 SHALL have ports req0_data / req1_data, input, DATA_W each, writeback data.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1 each, combinational grant; a transfer occurs when valid & ready.
REQ-009 SHALL have ports rsv_valid (input, 1) and rsv_addr (input, 5), which reserve a destination at dispatch.
REQ-010 SHALL have ports SA / SB, input, 5 each, the source addresses being read.
REQ-011 SHALL have ports hazard_a / hazard_b, output, 1 each, combinational pending-write flags for SA and SB.
REQ-012 SHALL have ports W (output, 1), DA (output, 5) and D (output, DATA_W), the registered register-file write port.
REQ-013 SHALL have ports busy (output, 32), the scoreboard, and rsv_err (output, 1), a registered one-cycle error pulse.

Function
REQ-014 SHALL grant at most one requester per cycle; both ready signals SHALL never be high together.
REQ-015 Arbitration SHALL be round-robin:
- one valid requester: that requester is granted;
- both valid: the requester not granted last is granted;
- last_grant updates only on an actual transfer.
REQ-016 A transfer in cycle N SHALL produce W=1, DA=addr and D=data in cycle N+1 for exactly one cycle (latency 1).
REQ-017 With no transfer, W SHALL be 0 and DA/D SHALL hold their previous values.
REQ-018 A transfer with addr==ZERO_REG SHALL be accepted (ready=1) but SHALL NOT assert W and SHALL NOT change busy.
REQ-019 rsv_valid with rsv_addr!=ZERO_REG SHALL set busy[rsv_addr] at the next edge; ZERO_REG reservations SHALL be ignored.
REQ-020 A transfer to addr A SHALL clear busy[A] at the same edge that registers W.
REQ-021 A simultaneous reserve and clear of the same address SHALL leave busy set (the reserve wins).
REQ-022 A reserve to an already-busy address SHALL keep busy set and SHALL pulse rsv_err for one cycle.
REQ-023 hazard_a SHALL equal busy[SA] & (SA!=ZERO_REG), and hazard_b likewise for SB; there is no bypass from same-cycle transfers.
REQ-024 A requester whose valid is low SHALL never be granted; ready SHALL NOT depend on the requester's own data.

Reset
REQ-025 While reset=0, outputs SHALL be W=0, DA=0, D=0, busy=0 and rsv_err=0, with last_grant=1 so that requester 0 wins the first tie.
REQ-026 Reset asserted mid-operation SHALL immediately drop W and clear busy; a transfer in flight SHALL be lost and SHALL NOT be written after deassertion.
REQ-027 ready outputs SHALL be 0 while reset=0.

Structure
REQ-028 A shared package SHALL hold ZERO_REG, the register count of 32, the address width of 5, and the requester-index encoding (ALU=0, MEM=1).
REQ-029 One sub-module, rr_arbiter2 (a 2-way round-robin arbiter with a last_grant flop), SHALL be used; the scoreboard and write-port registers SHALL stay in the top level.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reserve R5, then req0 writes R5 with data 0xDEAD: hazard_a=1 while SA=5 until the transfer edge; the next cycle shows W=1, DA=5, D=0xDEAD; busy[5]=0 afterward.
- req0 and req1 both valid for 4 cycles with addrs 1 and 2: grants alternate 0,1,0,1; W is high in each of the 4 following cycles.
- req1 writes R31 with data 0xFFFF: ready=1 and W stays 0; busy is unchanged and hazard_a=0 with SA=31.
- Reserve R7 and, in the same cycle, req0 writes R7: busy[7] remains 1 and rsv_err=0. Then reserve R7 again: rsv_err pulses for 1 cycle.
- Transfer to R3 in cycle N, reset pulled low in cycle N for half a cycle: W stays 0 and busy=0 after release, and the first tie grants req0.
